// File: rtl/ours_ppln_rr_arb_if.sv
// Requester and output channel bundle for the round-robin pipeline arbiter.
// master drives requests and out_ready; slave is the arbiter side.
interface ours_ppln_rr_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic                     out_last;
  logic [IDW-1:0]           out_id;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_id
  );
endinterface

// File: rtl/ours_ppln_rr_arb.sv
// Round-robin arbiter merging NUM_REQ streams into one registered channel.
// OURS_ARB_PKT_LOCK_EN: hold the grant until a packet's last beat is taken.
module ours_ppln_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rstn,
  ours_ppln_rr_arb_if.slave bus
);
  logic [IDW-1:0]   r_rr_ptr;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [IDW-1:0]   r_out_id;

  logic             w_can_load;
  logic             w_rr_found;
  logic [IDW-1:0]   w_rr_sel;
  logic [IDW-1:0]   w_sel;
  logic             w_sel_valid;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;
  logic [IDW-1:0]   w_ptr_nxt;

  assign w_can_load = ~r_out_valid | bus.out_ready;

  // Circular search from r_rr_ptr; index kept one bit wider to wrap safely.
  always_comb begin : rr_search
    logic [IDW:0] v_idx;
    w_rr_sel   = r_rr_ptr;
    w_rr_found = 1'b0;
    v_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (v_idx >= (IDW+1)'(NUM_REQ))
        v_idx = v_idx - (IDW+1)'(NUM_REQ);
      if (!w_rr_found && bus.req_valid[v_idx[IDW-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = v_idx[IDW-1:0];
      end
    end
  end

`ifdef OURS_ARB_PKT_LOCK_EN
  logic           r_lock;
  logic [IDW-1:0] r_lock_id;

  assign w_sel       = r_lock ? r_lock_id : w_rr_sel;
  assign w_sel_valid = r_lock ? bus.req_valid[r_lock_id]
                              : w_rr_found;
`else
  assign w_sel       = w_rr_sel;
  assign w_sel_valid = w_rr_found;
`endif

  assign w_accept   = rstn & w_can_load & w_sel_valid;
  assign w_sel_data = bus.req_data[int'(w_sel)*WIDTH +: WIDTH];
  assign w_sel_last = bus.req_last[w_sel];
  assign w_ptr_nxt  = (w_sel == IDW'(NUM_REQ-1)) ? '0
                                                 : w_sel + 1'b1;

  always_comb begin
    bus.req_ready = '0;
    if (w_accept)
      bus.req_ready[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_id    <= w_sel;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef OURS_ARB_PKT_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_rr_ptr  <= '0;
    end else if (w_accept) begin
      if (w_sel_last) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= w_ptr_nxt;
      end else begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rstn)
      r_rr_ptr <= '0;
    else if (w_accept)
      r_rr_ptr <= w_ptr_nxt;
  end
`endif

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_id    = r_out_id;
endmodule

// File: doc/ours_ppln_rr_arb.md
# ours_ppln_rr_arb

Round-robin arbiter that merges `NUM_REQ` valid/ready requester streams onto one shared downstream pipeline channel. It holds the grant across a packet until the beat carrying `last` is accepted. The output side is a one-entry registered stage, so the shared channel sees one register of latency. It sits in front of a shared pipeline stage that several upstream producers compete for.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 8: payload width.
- `IDW`, default `$clog2(NUM_REQ)`: grant id width.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester valid.
- `req_ready` out `NUM_REQ`: per-requester ready (one-hot or zero).
- `req_data` in `NUM_REQ*WIDTH`: requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_last` in `NUM_REQ`: final beat of packet.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream ready.
- `out_data` out `WIDTH`: registered payload.
- `out_last` out 1: registered last.
- `out_id` out `IDW`: index of the source requester.

## Operation
- **Output register.** `can_load = ~out_valid | out_ready`. A beat is accepted from requester i when `req_valid[i] & req_ready[i]`.
- **Ready generation.** `req_ready[i] = can_load & (sel == i) & sel_valid`. At most one bit is set. `req_ready` may depend combinationally on `req_valid` and `out_ready`.
- **Unlocked selection.** `sel` is the first requester with `req_valid` set, searching circularly from `rr_ptr` upward. `sel_valid` is 0 when no requester is valid.
- **Locked selection.** `sel = lock_id` and `sel_valid = req_valid[lock_id]`. Other requesters are ignored even if valid.
- **Lock set.** On acceptance of a beat with `req_last=0`: `lock <= 1`, `lock_id <= sel`.
- **Lock clear.** On acceptance of a beat with `req_last=1`: `lock <= 0`, `rr_ptr <= (sel+1) mod NUM_REQ`.
- **Pointer hold.** `rr_ptr` changes only on an accepted last beat.
- **Wrap-around.** When `sel = NUM_REQ-1`, `rr_ptr` wraps to 0. Non-power-of-two `NUM_REQ` must wrap correctly, with no out-of-range ids.
- **Output update on acceptance.** `out_data`, `out_last` and `out_id` load from the selected requester; `out_valid <= 1`.
- **Output drain.** If `out_valid & out_ready` and no acceptance occurs, `out_valid <= 0`.
- **Payload stability.** Output payload is stable while `out_valid & ~out_ready`.
- **Locked requester idle.** A locked requester dropping `req_valid` mid-packet stalls the channel (bubble). The lock is held and no other requester is granted.

## Timing
- **Reset values.** On reset (`rstn=0` at posedge): `out_valid=0`, `lock=0`, `rr_ptr=0`, `lock_id=0`, `out_id=0`, `out_last=0`, `out_data=0`.
- **Reset and ready.** `req_ready` is 0 during the reset cycle. Reset mid-packet drops the lock and any held beat; the partial packet is not replayed.
- **Latency.** A beat accepted at edge N drives `out_valid=1` from after edge N.
- **Throughput.** One beat per cycle when `out_ready` is held at 1.
- **Simultaneous drain and load.** When `out_valid & out_ready` and a new acceptance occur in the same cycle, the register reloads and `out_valid` stays 1.
- **Single-beat packets.** A beat with `req_last=1` and no prior lock never asserts `lock` and advances `rr_ptr` immediately.
- **Zero requesters valid.** Stays idle; `rr_ptr` is unchanged.

## Configuration
- **Macro:** `OURS_ARB_PKT_LOCK_EN`.
- **Defined:** packet locking as described above.
- **Undefined:** `lock`/`lock_id` are not implemented. Every beat is arbitrated independently, and `rr_ptr <= (sel+1) mod NUM_REQ` on every accepted beat. `req_last` passes through to `out_last` only.

## Test plan
- **Reset.** `rstn=0` for 2 cycles with all `req_valid=1` -> `out_valid=0` and `req_ready=0` throughout; first grant after reset is requester 0.
- **Fairness.** `NUM_REQ=4`; all requesters send single-beat packets, with `req_data[i]=8'h10+i`; `out_ready=1` -> `out_id` sequence 0,1,2,3,0 and one beat per cycle.
- **Packet lock (macro on).** Requester 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last on the third); requester 1 is valid throughout -> output 0xA0, 0xA1, 0xA2 from id 2, then id 1; `rr_ptr=3` after the last beat.
- **Backpressure.** `out_ready=0` for 5 cycles with a beat held -> `out_data`/`out_id` stable and `req_ready=0`; after `out_ready=1`, no beat is lost or duplicated.
- **Locked bubble.** Locked requester 0 deasserts `req_valid` for 2 cycles mid-packet while requester 3 is valid -> no grant to 3 until requester 0's last beat is accepted.
- **Per-beat arbitration (macro off).** Requesters 0 and 1 each send 2-beat packets -> `out_id` alternates 0,1,0,1.
